// File: rtl/bank_pkg.sv
// rtl/bank_pkg.sv - shared bank-mapping encodings and helpers
package bank_pkg;

    localparam int MAP_LINEAR = 0;
    localparam int MAP_XOR    = 1;

    function automatic int bank_bits(input int banks);
        return $clog2(banks);
    endfunction

endpackage

// File: rtl/bank_map.sv
// rtl/bank_map.sv - one-lane address to bank/row mapper (linear or XOR swizzle)
module bank_map
    import bank_pkg::*;
#(
    parameter  int ADDR_WIDTH = 32,
    parameter  int BANKS      = 8,
    parameter  int MODE       = MAP_XOR,
    localparam int BANK_BITS  = bank_bits(BANKS),
    localparam int ROW_W      = ADDR_WIDTH - BANK_BITS
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [BANK_BITS-1:0]  bank,
    output logic [ROW_W-1:0]      row
);

    assign row = addr[ADDR_WIDTH-1:BANK_BITS];

    generate
        if (MODE == MAP_XOR) begin : g_xor
            // Folding the low row bits into the bank spreads power-of-two strides
            assign bank = addr[BANK_BITS-1:0] ^ addr[2*BANK_BITS-1:BANK_BITS];
        end else begin : g_linear
            assign bank = addr[BANK_BITS-1:0];
        end
    endgenerate

endmodule

// File: rtl/bank_conflict_sched.sv
// rtl/bank_conflict_sched.sv - splits a lane request vector into conflict-free bank beats
module bank_conflict_sched
    import bank_pkg::*;
#(
    parameter  int ADDR_WIDTH = 32,
    parameter  int BANKS      = 8,
    parameter  int LANES      = 4,
    parameter  int MODE       = MAP_XOR,
    localparam int BANK_BITS  = bank_bits(BANKS),
    localparam int ROW_W      = ADDR_WIDTH - BANK_BITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*ADDR_WIDTH-1:0] in_addr,
    input  logic [LANES-1:0]            in_mask,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES-1:0]            out_lane_mask,
    output logic [LANES*BANK_BITS-1:0]  out_bank,
    output logic [LANES*ROW_W-1:0]      out_row,
    output logic                        out_last,
    output logic [15:0]                 replay_cnt
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]                      state;
    logic [LANES-1:0]                pend;
    logic                            first;
    logic [15:0]                     replay;
    logic [LANES-1:0][BANK_BITS-1:0] bank_r;
    logic [LANES-1:0][ROW_W-1:0]     row_r;
    logic [LANES-1:0][BANK_BITS-1:0] map_bank;
    logic [LANES-1:0][ROW_W-1:0]     map_row;
    logic [LANES-1:0]                served;
    logic                            beat_take;
    logic                            accept;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            bank_map #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .BANKS      (BANKS),
                .MODE       (MODE)
            ) u_map (
                .addr (in_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
                .bank (map_bank[g]),
                .row  (map_row[g])
            );
        end
    endgenerate

    // The lowest pending lane of each bank picks that bank's row for this beat
    always_comb begin
        logic             lead_found;
        logic [ROW_W-1:0] lead_row;
        served     = '0;
        lead_found = 1'b0;
        lead_row   = '0;
        for (int i = 0; i < LANES; i++) begin
            lead_found = 1'b0;
            lead_row   = '0;
            for (int j = 0; j < LANES; j++) begin
                if (!lead_found && pend[j] && (bank_r[j] == bank_r[i])) begin
                    lead_found = 1'b1;
                    lead_row   = row_r[j];
                end
            end
            served[i] = pend[i] && lead_found && (row_r[i] == lead_row);
        end
    end

    assign out_valid     = (state == ISSUE);
    assign out_lane_mask = out_valid ? served : '0;
    assign out_last      = out_valid && ((pend & ~served) == '0);
    assign out_bank      = bank_r;
    assign out_row       = row_r;
    assign replay_cnt    = replay;

    assign beat_take = out_valid && out_ready;
    assign in_ready  = (state == IDLE) || (beat_take && out_last);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pend   <= '0;
            first  <= 1'b0;
            replay <= '0;
            bank_r <= '0;
            row_r  <= '0;
        end else begin
            if (beat_take) begin
                pend  <= pend & ~served;
                first <= 1'b0;
                if (!first && (replay != 16'hFFFF)) begin
                    replay <= replay + 16'd1;
                end
                if (out_last) begin
                    state <= IDLE;
                end
            end
            // An accept overrides the retiring beat so back-to-back vectors have no bubble
            if (accept) begin
                bank_r <= map_bank;
                row_r  <= map_row;
                pend   <= in_mask;
                first  <= 1'b1;
                state  <= (in_mask != '0) ? ISSUE : IDLE;
            end
        end
    end

endmodule

// File: tb/tb_bank_conflict_sched.sv
// tb/tb_bank_conflict_sched.sv - directed bench with per-cycle behavioural model compare
module tb_bank_conflict_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_addr = '0;
    logic [3:0]   in_mask = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [3:0]   out_lane_mask;
    logic [11:0]  out_bank;
    logic [115:0] out_row;
    logic         out_last;
    logic [15:0]  replay_cnt;

    int n_vec = 0;
    int n_mis = 0;

    bank_conflict_sched #(
        .ADDR_WIDTH (32),
        .BANKS      (8),
        .LANES      (4),
        .MODE       (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_addr       (in_addr),
        .in_mask       (in_mask),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_lane_mask (out_lane_mask),
        .out_bank      (out_bank),
        .out_row       (out_row),
        .out_last      (out_last),
        .replay_cnt    (replay_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining beat masks of the current vector, plus mapped registers
    logic [3:0]   m_beats[$];
    logic         m_first = 1'b0;
    int           m_replay = 0;
    logic [11:0]  m_bank = '0;
    logic [115:0] m_row = '0;
    logic [3:0]   obs[$];
    logic [11:0]  obs_bank[$];

    function automatic void plan(input logic [127:0] a, input logic [3:0] m);
        logic [3:0] pnd;
        logic [3:0] srv;
        int         bk[4];
        int         rw[4];
        bit         found;
        int         r;
        for (int l = 0; l < 4; l++) begin
            int unsigned v;
            v = a[l*32 +: 32];
            bk[l] = int'((v ^ (v >> 3)) & 32'd7);
            rw[l] = int'(v >> 3);
            m_bank[l*3 +: 3]   = 3'(bk[l]);
            m_row[l*29 +: 29]  = 29'(v >> 3);
        end
        m_beats.delete();
        pnd = m;
        while (pnd != 4'd0) begin
            srv = 4'd0;
            for (int b = 0; b < 8; b++) begin
                found = 1'b0;
                r = 0;
                for (int l = 0; l < 4; l++) begin
                    if (!found && pnd[l] && bk[l] == b) begin
                        found = 1'b1;
                        r = rw[l];
                    end
                end
                for (int l = 0; l < 4; l++) begin
                    if (found && pnd[l] && bk[l] == b && rw[l] == r) srv[l] = 1'b1;
                end
            end
            m_beats.push_back(srv);
            pnd = pnd & ~srv;
        end
    endfunction

    logic       prev_stall = 1'b0;
    logic [3:0] prev_mask;
    logic       prev_last;

    always @(negedge clk) begin
        logic       e_valid;
        logic [3:0] e_mask;
        logic       e_last;
        logic       e_ready;
        e_valid = (m_beats.size() != 0);
        e_mask  = e_valid ? m_beats[0] : 4'd0;
        e_last  = e_valid && (m_beats.size() == 1);
        e_ready = !e_valid || (out_ready && e_last);
        chk("out_valid", 128'(out_valid), 128'(e_valid));
        chk("out_lane_mask", 128'(out_lane_mask), 128'(e_mask));
        chk("out_last", 128'(out_last), 128'(e_last));
        chk("in_ready", 128'(in_ready), 128'(e_ready));
        chk("replay_cnt", 128'(replay_cnt), 128'(m_replay));
        chk("out_bank", 128'(out_bank), 128'(m_bank));
        chk("out_row", 128'(out_row), 128'(m_row));
        if (prev_stall) begin
            chk("stall_hold_mask", 128'(out_lane_mask), 128'(prev_mask));
            chk("stall_hold_last", 128'(out_last), 128'(prev_last));
        end
        prev_stall = out_valid && !out_ready && !rst;
        prev_mask  = out_lane_mask;
        prev_last  = out_last;
        if (rst) begin
            m_beats.delete();
            m_first  = 1'b0;
            m_replay = 0;
            m_bank   = '0;
            m_row    = '0;
        end else begin
            if (e_valid && out_ready) begin
                obs.push_back(out_lane_mask);
                obs_bank.push_back(out_bank);
                if (!m_first && m_replay < 16'hFFFF) m_replay++;
                void'(m_beats.pop_front());
                m_first = 1'b0;
            end
            if (in_valid && e_ready) begin
                plan(in_addr, in_mask);
                m_first = 1'b1;
            end
        end
    end

    function automatic logic [127:0] lanes(input logic [31:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        obs.delete();
        obs_bank.delete();
    endtask

    task automatic send(input logic [127:0] a, input logic [3:0] m);
        int k;
        in_addr  = a;
        in_mask  = m;
        in_valid = 1'b1;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (k == 100) chk("accept_timeout", 128'd0, 128'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!out_valid) break;
        end
        if (k == 200) chk("drain_timeout", 128'd0, 128'd1);
        step();
    endtask

    task automatic chk_obs(input string nm, input int n, input logic [63:0] e);
        chk({nm, "_beats"}, 128'(obs.size()), 128'(n));
        for (int i = 0; i < n && i < obs.size(); i++) begin
            chk({nm, "_mask"}, 128'(obs[i]), 128'(e[i*4 +: 4]));
        end
    endtask

    logic [127:0] v_seq;
    logic [127:0] v_conf;
    logic [127:0] v_bcast;

    initial begin
        v_seq   = lanes(32'h0, 32'h1, 32'h2, 32'h3);
        v_conf  = lanes(32'h00, 32'h09, 32'h12, 32'h1B);
        v_bcast = lanes(32'h40, 32'h40, 32'h40, 32'h40);

        do_reset();
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_replay", 128'(replay_cnt), 128'd0);

        // Distinct banks: single beat
        send(v_seq, 4'hF);
        drain();
        chk_obs("seq", 1, 64'hF);
        chk("seq_bank", 128'(obs_bank[0]), 128'(12'h688));
        chk("seq_replay", 128'(replay_cnt), 128'd0);

        // Same bank, four rows: serialised
        do_reset();
        send(v_conf, 4'hF);
        drain();
        chk_obs("conf", 4, 64'h8421);
        chk("conf_replay", 128'(replay_cnt), 128'd3);

        // Broadcast
        do_reset();
        send(v_bcast, 4'hF);
        drain();
        chk_obs("bcast", 1, 64'hF);
        chk("bcast_replay", 128'(replay_cnt), 128'd0);

        // Stall after beat 1
        do_reset();
        out_ready = 1'b0;
        send(v_conf, 4'hF);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        drain();
        chk_obs("stall", 4, 64'h8421);
        chk("stall_replay", 128'(replay_cnt), 128'd3);

        // Back-to-back vector during last beat
        do_reset();
        send(v_conf, 4'hF);
        repeat (3) step();
        in_addr  = v_seq;
        in_mask  = 4'hF;
        in_valid = 1'b1;
        @(negedge clk);
        chk("b2b_last", 128'(out_last), 128'd1);
        chk("b2b_in_ready", 128'(in_ready), 128'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_next_valid", 128'(out_valid), 128'd1);
        chk("b2b_next_mask", 128'(out_lane_mask), 128'hF);
        step();
        drain();
        chk_obs("b2b", 5, 64'hF8421);
        chk("b2b_replay", 128'(replay_cnt), 128'd3);

        // Reset during beat 2
        do_reset();
        send(v_conf, 4'hF);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        chk("rstmid_beats", 128'(obs.size()), 128'd1);
        chk("rstmid_valid", 128'(out_valid), 128'd0);
        chk("rstmid_ready", 128'(in_ready), 128'd1);
        chk("rstmid_replay", 128'(replay_cnt), 128'd0);

        // Empty mask: accepted, no beat
        do_reset();
        send(v_conf, 4'h0);
        repeat (4) step();
        chk("empty_beats", 128'(obs.size()), 128'd0);
        chk("empty_valid", 128'(out_valid), 128'd0);

        // Partial mask: lanes 0 and 2 share bank 0 on different rows
        do_reset();
        send(v_conf, 4'h5);
        drain();
        chk_obs("partial", 2, 64'h41);
        chk("partial_replay", 128'(replay_cnt), 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/bank_conflict_sched.md
BANK_CONFLICT_SCHED -- requirements
Module: bank_conflict_sched

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte/word address width per lane.
REQ-002 SHALL have parameter BANKS, default 8, bank count, power of two, at least 2; BANK_BITS = log2(BANKS) and ROW_W = ADDR_WIDTH-BANK_BITS.
REQ-003 SHALL have parameter LANES, default 4, request lanes per vector.
REQ-004 SHALL have parameter MODE, default 1, where 0 means linear (bank = addr low bits) and 1 means XOR swizzle (bank = low ^ (addr>>BANK_BITS)[BANK_BITS-1:0]).
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  request vector valid.
REQ-008 in_ready  out  1  request accepted when in_valid&&in_ready.
REQ-009 in_addr  in  LANES*ADDR_WIDTH  lane i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 in_mask  in  LANES  active lanes.
REQ-011 out_valid  out  1  issue beat valid.
REQ-012 out_ready  in  1  beat consumed when out_valid&&out_ready.
REQ-013 out_lane_mask  out  LANES  lanes served this beat.
REQ-014 out_bank  out  LANES*BANK_BITS  mapped bank per lane (registered at accept).
REQ-015 out_row  out  LANES*ROW_W  row = addr>>BANK_BITS per lane.
REQ-016 out_last  out  1  final beat of current vector.
REQ-017 replay_cnt  out  16  saturating count of beats beyond the first per vector.

Function
REQ-018 SHALL map each lane with the MODE rule on accept and hold bank/row in registers until the next accept.
REQ-019 SHALL use a two-state FSM, IDLE and ISSUE; pending mask P is loaded with in_mask on accept.
REQ-020 in_ready SHALL be 1 in IDLE, or in ISSUE when out_valid&&out_ready&&out_last; otherwise 0.
REQ-021 Accept with in_mask!=0 SHALL go to ISSUE, with out_valid=1 the next cycle (latency 1).
REQ-022 Accept with in_mask==0 SHALL produce no beat and SHALL remain in IDLE.
REQ-023 Beat selection: pending lane i is served iff its row equals the row of the lowest-index pending lane with the same bank; this gives one row per bank per beat, with same-row broadcast merged.
REQ-024 out_lane_mask SHALL be that served set, computed from the current P; out_last SHALL be 1 iff P & ~served == 0.
REQ-025 On a consumed beat, P <= P & ~served; a consumed last beat SHALL go to IDLE, unless a new vector is accepted in the same cycle, in which case the FSM SHALL stay in ISSUE with the new P, with no bubble.
REQ-026 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-027 replay_cnt SHALL increment on each consumed non-first beat of a vector and SHALL saturate at 0xFFFF.
REQ-028 out_bank/out_row for lanes outside out_lane_mask are don't-care for consumers but SHALL still be the registered values.

Reset
REQ-029 Reset SHALL set: FSM IDLE, P=0, out_valid=0, out_lane_mask=0, out_last=0, replay_cnt=0, bank/row registers=0; in_ready=1 the cycle after reset deasserts.
REQ-030 Reset mid-vector SHALL discard all pending lanes; no beat SHALL appear after reset.

Structure
REQ-031 Shared package bank_pkg SHALL hold the MODE encodings (MAP_LINEAR=0, MAP_XOR=1) and a bank_bits function.
REQ-032 A combinational sub-module bank_map (one lane: addr -> bank, row, with MODE) SHALL be instantiated LANES times; the scheduler logic stays in bank_conflict_sched.

Verification (BANKS=8, LANES=4, MODE=1, ADDR_WIDTH=32)
REQ-033 addrs {3,2,1,0} (lane3..0), mask 1111 -> banks 3,2,1,0; one beat mask 1111, last=1, replay_cnt=0.
REQ-034 addrs lane0..3 = 0x00,0x09,0x12,0x1B (all bank 0, rows 0..3) -> four beats with masks 0001,0010,0100,1000, last on the 4th, replay_cnt=3.
REQ-035 all lanes addr 0x40 -> one beat mask 1111 (broadcast), last=1.
REQ-036 REQ-034 stimulus with out_ready=0 for 3 cycles after beat 1 -> outputs frozen, same 4 beats in order, none lost or duplicated.
REQ-037 new vector (REQ-033 stimulus) presented during the last beat of REQ-034 with out_ready=1 -> accepted that cycle; its beat appears the next cycle.
REQ-038 rst=1 during beat 2 of REQ-034 -> out_valid=0, in_ready=1, replay_cnt=0 after reset; no further beats.
